// File: rtl/tx_pkt_sched.sv
// Transmit scheduler: pulls 12-bit pixels from frame memory, packs pairs into
// 3 bytes and frames each payload run with sync word, header and packet index.
module tx_pkt_sched #(
    parameter int          PAYLOAD_PIX = 40,
    parameter int          TOTAL_PIX   = 38400,
    parameter int          DATA_LAT    = 5,
    parameter int          GAP_CYC     = 16,
    parameter logic [23:0] FRAME1      = 24'haab155,
    parameter logic [23:0] FRAME0      = 24'haa8d55,
    parameter logic [7:0]  HSYNC       = 8'h55
) (
    input  logic        Cclk,
    input  logic        rstn,
    input  logic        tran_en,
    input  logic        frame_odd,
    input  logic [11:0] tran_data,
    output logic        next_data,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        pkt_start,
    output logic        pkt_last,
    output logic        frame_done,
    output logic        busy
);

    localparam int PP_W  = $clog2(PAYLOAD_PIX + 1);
    localparam int LAT_W = $clog2(DATA_LAT + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [PP_W-1:0]  PAYLOAD_L = PP_W'(PAYLOAD_PIX);
    localparam logic [16:0]      TOTAL_L   = 17'(TOTAL_PIX);
    localparam logic [LAT_W-1:0] LAT_L     = LAT_W'(DATA_LAT);
    localparam logic [GAP_W-1:0] GAP_L     = GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SYNC, ST_HDR, ST_FETCH_A, ST_FETCH_B, ST_SEND, ST_GAP, ST_DONE
    } state_t;

    state_t            state_r, next_state_s;
    logic              tran_en_q_r, frame_odd_q_r;
    logic [16:0]       pix_cnt_r;
    logic [15:0]       pkt_idx_r;
    logic [PP_W-1:0]   pkt_pix_r;
    logic [LAT_W-1:0]  lat_cnt_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic [1:0]        byte_idx_r;
    logic [11:0]       pa_r, pb_r;
    logic [7:0]        byte_data_r;
    logic              byte_valid_r, next_data_r, pkt_start_r, pkt_last_r, frame_done_r;

    logic              start_s, abort_s, send_state_s, xfer_s, last_byte_s;
    logic              fetch_done_s, pair_last_s, frame_end_s, gap_end_s;
    logic [1:0]        sel_idx_s;

    // Byte lanes of each send state are laid out as one 24-bit word, MSB byte first.
    function automatic logic [7:0] byte_sel(input state_t st, input logic [1:0] idx,
                                            input logic [23:0] sync, input logic [15:0] pidx,
                                            input logic [11:0] a, input logic [11:0] b);
        logic [23:0] w;
        case (st)
            ST_SYNC: w = sync;
            ST_HDR:  w = {HSYNC, pidx};
            ST_SEND: w = {a, b};
            default: w = 24'h000000;
        endcase
        case (idx)
            2'd0:    byte_sel = w[23:16];
            2'd1:    byte_sel = w[15:8];
            default: byte_sel = w[7:0];
        endcase
    endfunction

    assign start_s      = tran_en & ~tran_en_q_r;
    assign abort_s      = ~tran_en & (state_r != ST_IDLE) & (state_r != ST_DONE);
    assign send_state_s = (state_r == ST_SYNC) | (state_r == ST_HDR) | (state_r == ST_SEND);
    assign xfer_s       = byte_valid_r & byte_ready;
    assign last_byte_s  = xfer_s & (byte_idx_r == 2'd2);
    assign fetch_done_s = (lat_cnt_r == LAT_L);
    assign pair_last_s  = ((pkt_pix_r + PP_W'(2)) == PAYLOAD_L);
    assign frame_end_s  = (pix_cnt_r == TOTAL_L);
    assign gap_end_s    = (gap_cnt_r == GAP_L);
    assign sel_idx_s    = xfer_s ? (byte_idx_r + 2'd1) : byte_idx_r;

    // State register.
    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; abort overrides every transition out of an active state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:    if (start_s) next_state_s = ST_SYNC; else next_state_s = ST_IDLE;
            ST_SYNC:    if (last_byte_s) next_state_s = ST_HDR; else next_state_s = ST_SYNC;
            ST_HDR:     if (last_byte_s) next_state_s = ST_FETCH_A; else next_state_s = ST_HDR;
            ST_FETCH_A: if (fetch_done_s) next_state_s = ST_FETCH_B; else next_state_s = ST_FETCH_A;
            ST_FETCH_B: if (fetch_done_s) next_state_s = ST_SEND; else next_state_s = ST_FETCH_B;
            ST_SEND: begin
                if (last_byte_s) next_state_s = pair_last_s ? ST_GAP : ST_FETCH_A;
                else             next_state_s = ST_SEND;
            end
            ST_GAP: begin
                if (frame_end_s)    next_state_s = ST_DONE;
                else if (gap_end_s) next_state_s = ST_SYNC;
                else                next_state_s = ST_GAP;
            end
            ST_DONE:    next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
        if (abort_s) begin
            next_state_s = ST_IDLE;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // Datapath: counters, pixel capture and registered byte/strobe outputs.
    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            tran_en_q_r   <= 1'b1;  // a level already high out of reset is not an edge
            frame_odd_q_r <= 1'b0;
            pix_cnt_r     <= 17'd0;
            pkt_idx_r     <= 16'd0;
            pkt_pix_r     <= '0;
            lat_cnt_r     <= '0;
            gap_cnt_r     <= '0;
            byte_idx_r    <= 2'd0;
            pa_r          <= 12'd0;
            pb_r          <= 12'd0;
            byte_data_r   <= 8'd0;
            byte_valid_r  <= 1'b0;
            next_data_r   <= 1'b0;
            pkt_start_r   <= 1'b0;
            pkt_last_r    <= 1'b0;
            frame_done_r  <= 1'b0;
        end else begin
            tran_en_q_r <= tran_en;
            if ((state_r == ST_IDLE) && start_s) begin
                frame_odd_q_r <= frame_odd;
                pix_cnt_r     <= 17'd0;
                pkt_idx_r     <= 16'd0;
                pkt_pix_r     <= '0;
            end else if ((state_r == ST_SEND) && last_byte_s) begin
                pix_cnt_r <= pix_cnt_r + 17'd2;
                pkt_pix_r <= pair_last_s ? '0 : (pkt_pix_r + PP_W'(2));
                pkt_idx_r <= pair_last_s ? (pkt_idx_r + 16'd1) : pkt_idx_r;
            end

            if (abort_s || last_byte_s) byte_idx_r <= 2'd0;
            else if (xfer_s)            byte_idx_r <= byte_idx_r + 2'd1;

            if (abort_s || last_byte_s) begin
                byte_valid_r <= 1'b0;
                pkt_last_r   <= 1'b0;
            end else if (send_state_s && (!byte_valid_r || xfer_s)) begin
                byte_valid_r <= 1'b1;
                byte_data_r  <= byte_sel(state_r, sel_idx_s,
                                         frame_odd_q_r ? FRAME1 : FRAME0, pkt_idx_r, pa_r, pb_r);
                pkt_last_r   <= (state_r == ST_SEND) && (sel_idx_s == 2'd2) && pair_last_s;
            end

            if (((state_r == ST_FETCH_A) || (state_r == ST_FETCH_B)) && !fetch_done_s)
                lat_cnt_r <= lat_cnt_r + LAT_W'(1);
            else
                lat_cnt_r <= '0;
            if ((state_r == ST_FETCH_A) && fetch_done_s) pa_r <= tran_data;
            if ((state_r == ST_FETCH_B) && fetch_done_s) pb_r <= tran_data;

            gap_cnt_r    <= (state_r == ST_GAP) ? (gap_cnt_r + GAP_W'(1)) : '0;
            next_data_r  <= ((next_state_s == ST_FETCH_A) && (state_r != ST_FETCH_A)) ||
                            ((next_state_s == ST_FETCH_B) && (state_r != ST_FETCH_B));
            pkt_start_r  <= xfer_s && !abort_s && (state_r == ST_SYNC) && (byte_idx_r == 2'd0);
            frame_done_r <= (state_r == ST_GAP) && (next_state_s == ST_DONE);
        end
    end

    assign next_data  = next_data_r;
    assign byte_data  = byte_data_r;
    assign byte_valid = byte_valid_r;
    assign pkt_start  = pkt_start_r;
    assign pkt_last   = pkt_last_r;
    assign frame_done = frame_done_r;
    assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_tx_pkt_sched.sv
// Directed bench for tx_pkt_sched: two 4-pixel packets per frame, a latency-modelled
// pixel memory, a byte monitor and hand-computed expected byte streams.
module tb_tx_pkt_sched;

    localparam int PP  = 4;
    localparam int TP  = 8;
    localparam int LAT = 5;
    localparam int GAP = 16;

    logic        Cclk = 1'b0;
    logic        rstn = 1'b0;
    logic        tran_en = 1'b0;
    logic        frame_odd = 1'b0;
    logic        byte_ready = 1'b0;
    logic [11:0] tran_data;
    logic        next_data, byte_valid, pkt_start, pkt_last, frame_done, busy;
    logic [7:0]  byte_data;

    int checks = 0;
    int errors = 0;

    always #5 Cclk = ~Cclk;

    tx_pkt_sched #(.PAYLOAD_PIX(PP), .TOTAL_PIX(TP), .DATA_LAT(LAT), .GAP_CYC(GAP)) u_dut (
        .Cclk(Cclk), .rstn(rstn), .tran_en(tran_en), .frame_odd(frame_odd),
        .tran_data(tran_data), .next_data(next_data), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .pkt_start(pkt_start),
        .pkt_last(pkt_last), .frame_done(frame_done), .busy(busy)
    );

    logic [11:0] pix_tab [0:7]  = '{12'hABC, 12'h123, 12'h456, 12'h789,
                                    12'hDEF, 12'h024, 12'h68A, 12'hCE0};
    logic [7:0]  pay_tab [0:11] = '{8'hAB, 8'hC1, 8'h23, 8'h45, 8'h67, 8'h89,
                                    8'hDE, 8'hF0, 8'h24, 8'h68, 8'hAC, 8'hE0};

    // Pixel memory: data for a request appears DATA_LAT cycles after the pulse.
    int cyc = 0, nd_cnt = 0, nd_base = 0, dly = 0, rd_idx = 0, last_nd = -100, nd_close = 0;
    always @(posedge Cclk) begin
        cyc <= cyc + 1;
        if (next_data) begin
            if (nd_cnt > 0 && (cyc - last_nd) < LAT + 1) nd_close <= nd_close + 1;
            last_nd   <= cyc;
            nd_cnt    <= nd_cnt + 1;
            rd_idx    <= nd_cnt - nd_base;
            dly       <= LAT - 1;
            tran_data <= 12'hEEE;
        end else if (dly > 1) begin
            dly <= dly - 1;
        end else if (dly == 1) begin
            tran_data <= pix_tab[rd_idx[2:0]];
            dly       <= 0;
        end
    end

    // Byte monitor: records transfers, counts strobes, measures idle runs and hold stability.
    logic [7:0] byte_q [0:255];
    logic       last_q [0:255];
    int nbytes = 0, ps_cnt = 0, fd_cnt = 0, idle_run = 0, gap_run = 0, gap_base = 0, unstable = 0;
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'd0;
    always @(negedge Cclk) begin
        if (byte_valid && byte_ready) begin
            byte_q[nbytes % 256] <= byte_data;
            last_q[nbytes % 256] <= pkt_last;
            nbytes <= nbytes + 1;
            if (nbytes - gap_base == 12) gap_run <= idle_run;
        end
        if (hold_v && (!byte_valid || byte_data != hold_d)) unstable <= unstable + 1;
        hold_v <= byte_valid && !byte_ready;
        hold_d <= byte_data;
        if (pkt_start)  ps_cnt <= ps_cnt + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        idle_run <= (busy && !byte_valid) ? idle_run + 1 : 0;
    end

    // Ready generator: 0 = always ready, 1 = ready one cycle in three, 2 = never ready.
    int rdy_mode = 2;
    initial forever begin
        @(posedge Cclk);
        #1;
        if (rdy_mode == 1) byte_ready = (cyc % 3 == 0);
        else               byte_ready = (rdy_mode == 0);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i, input bit odd);
        logic [23:0] s;
        int p, j;
        s = odd ? 24'haab155 : 24'haa8d55;
        p = i / 12;
        j = i % 12;
        if (j < 3)       return s[23 - 8*j -: 8];
        else if (j == 3) return 8'h55;
        else if (j == 4) return 8'h00;
        else if (j == 5) return 8'(p);
        else             return pay_tab[p*6 + j - 6];
    endfunction

    task automatic run_frame(input bit odd, input string tag);
        int b0, nd0, ps0, fd0;
        bit ok;
        b0 = nbytes; nd0 = nd_cnt; ps0 = ps_cnt; fd0 = fd_cnt;
        @(posedge Cclk); #1;
        nd_base = nd_cnt; gap_base = nbytes; frame_odd = odd; tran_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge Cclk); #1;
            ok = (fd_cnt != fd0);
        end
        check_val({tag, "_done"}, 32'(ok), 32'd1);
        repeat (3) @(negedge Cclk);
        #1;
        check_val({tag, "_nbytes"}, 32'(nbytes - b0), 32'd24);
        for (int i = 0; i < 24; i++) begin
            check_val($sformatf("%s_byte%0d", tag, i), 32'(byte_q[(b0 + i) % 256]), 32'(exp_byte(i, odd)));
            check_val($sformatf("%s_last%0d", tag, i), 32'(last_q[(b0 + i) % 256]),
                      32'(i == 11 || i == 23));
        end
        check_val({tag, "_next_data"}, 32'(nd_cnt - nd0), 32'(TP));
        check_val({tag, "_pkt_start"}, 32'(ps_cnt - ps0), 32'(TP / PP));
        check_val({tag, "_frame_done"}, 32'(fd_cnt - fd0), 32'd1);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        if (rdy_mode == 0) check_val({tag, "_gap"}, 32'(gap_run), 32'(GAP + 1));
        tran_en = 1'b0;
        repeat (2) @(posedge Cclk);
    endtask

    initial begin
        int b0, fd0;
        repeat (3) @(negedge Cclk);
        check_val("rst_next_data", 32'(next_data), 32'd0);
        check_val("rst_byte_valid", 32'(byte_valid), 32'd0);
        check_val("rst_byte_data", 32'(byte_data), 32'd0);
        check_val("rst_pkt_start", 32'(pkt_start), 32'd0);
        check_val("rst_pkt_last", 32'(pkt_last), 32'd0);
        check_val("rst_frame_done", 32'(frame_done), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        tran_en = 1'b1;
        @(negedge Cclk); rstn = 1'b1;
        repeat (30) @(negedge Cclk);
        check_val("held_en_busy", 32'(busy), 32'd0);
        check_val("held_en_nd", 32'(nd_cnt), 32'd0);
        tran_en = 1'b0;
        rdy_mode = 0;
        repeat (3) @(posedge Cclk);

        run_frame(1'b1, "odd");
        run_frame(1'b0, "even");
        rdy_mode = 1;
        run_frame(1'b1, "bp");
        check_val("bp_stable", 32'(unstable), 32'd0);
        check_val("nd_spacing", 32'(nd_close), 32'd0);
        rdy_mode = 0;

        // Abort after the fifth byte, then restart from the sync word.
        b0 = nbytes; fd0 = fd_cnt;
        @(posedge Cclk); #1;
        frame_odd = 1'b1; tran_en = 1'b1;
        for (int i = 0; i < 500 && (nbytes - b0) < 5; i++) begin
            @(negedge Cclk); #1;
        end
        check_val("abort_reach5", 32'(nbytes - b0 >= 5), 32'd1);
        @(posedge Cclk); #1;
        tran_en = 1'b0;
        @(posedge Cclk); #1;
        check_val("abort_valid", 32'(byte_valid), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_nd", 32'(next_data), 32'd0);
        check_val("abort_last", 32'(pkt_last), 32'd0);
        for (int i = 0; i < 5; i++)
            check_val($sformatf("abort_byte%0d", i), 32'(byte_q[(b0 + i) % 256]), 32'(exp_byte(i, 1'b1)));
        repeat (50) @(negedge Cclk);
        #1;
        check_val("abort_no_done", 32'(fd_cnt - fd0), 32'd0);
        run_frame(1'b1, "restart");

        // Asynchronous reset in the middle of a packet.
        b0 = nbytes;
        @(posedge Cclk); #1;
        tran_en = 1'b1;
        for (int i = 0; i < 500 && (nbytes - b0) < 8; i++) begin
            @(negedge Cclk); #1;
        end
        @(posedge Cclk); #2;
        rstn = 1'b0;
        #1;
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_valid", 32'(byte_valid), 32'd0);
        tran_en = 1'b0;
        repeat (2) @(negedge Cclk);
        rstn = 1'b1;
        repeat (2) @(posedge Cclk);
        run_frame(1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
